rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources.
  - Requester A: ALU / short-latency results.
  - Requester B: load or multiply/divide / long-latency results.
- Each requester gets a one-entry holding buffer with a valid/ready handshake.
- Round-robin arbitration between the buffers; registered write-port outputs.
- A per-register pending scoreboard tells the controller when operands at the read addresses are not yet written.

Parameters:
- NREG, 32, number of architectural registers (address width fixed at 5)
- DW, 32, write data width

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- a_valid_i  in  1  requester A offers a write
- a_ready_o  out  1  A holding buffer can accept
- a_addr_i  in  5  A destination register
- a_data_i  in  DW  A write data
- b_valid_i  in  1  requester B offers a write
- b_ready_o  out  1  B holding buffer can accept
- b_addr_i  in  5  B destination register
- b_data_i  in  DW  B write data
- we3_o  out  1  register file write enable
- a3_o  out  5  register file write address
- wd3_o  out  DW  register file write data
- ra1_i, ra2_i  in  5 each  read addresses under hazard check
- busy1_o, busy2_o  out  1 each  pending write exists to ra1_i / ra2_i (combinational)
- idle_o  out  1  both buffers empty and we3_o low

Behaviour:
- Reset (async, reset_n low):
  - buffers empty; scoreboard all 0; round-robin pointer = A
  - we3_o=0, a3_o=0, wd3_o=0; a_ready_o=b_ready_o=1; idle_o=1
- Accept:
  - A transfer occurs on a rising edge with x_valid_i & x_ready_o; it loads the holding buffer.
  - x_ready_o = buffer empty OR buffer granted this cycle (drain-and-refill allowed).
- Arbitration (combinational from buffer state, each cycle):
  - One full buffer -> grant it.
  - Both full -> grant per round-robin pointer.
  - Pointer toggles to the other requester after each grant made while both buffers were full.
  - Exception: same destination address in both buffers -> grant the older entry regardless of the pointer.
    - An age bit records which buffer filled first.
    - Same-edge fill to the same address -> B is older.
- Commit:
  - Granted entry is registered onto a3_o/wd3_o with we3_o=1 for exactly one cycle.
  - The buffer frees on the same edge.
  - Latency: accept edge N -> we3_o high in cycle N+2 at the earliest -> register file updated at end of cycle N+2.
- Sustained throughput: one write per cycle.
- $zero (addr 0):
  - Accepted and arbitrated normally.
  - Commit drives we3_o=0 (the slot is consumed).
  - Never marks the scoreboard.
- Scoreboard:
  - pending[r] set on the accept edge (r != 0).
  - Cleared on the edge ending the cycle in which we3_o=1 with a3_o=r, unless another buffer or a same-edge accept still targets r.
  - busy1_o = pending[ra1_i]; busy2_o = pending[ra2_i]; always 0 for address 0.
- Simultaneous accept and commit clear on the same register: set wins.
- Reset mid-operation: buffered and in-flight writes are discarded; no we3_o pulse follows reset release.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- Defined:
  - Adds outputs fwd1_o, fwd2_o (DW) and fwd1_hit_o, fwd2_hit_o.
  - On a match to ra1_i/ra2_i against the youngest pending entry (holding buffers or the registered write stage), the hit is asserted and the data forwarded.
  - busy1_o/busy2_o are then low for that address.
- Undefined: those ports are absent; busy outputs behave as above.

Test Plan:
- Single A write: reset, then a_valid_i=1, a_addr_i=5, a_data_i=0x1234 for one cycle.
  - we3_o=1, a3_o=5, wd3_o=0x1234 exactly two cycles later.
  - busy1_o=1 for ra1_i=5 from the accept edge until the commit edge, then 0.
- Contention: both buffers full with A->3 and B->4, held continuously valid with new addresses.
  - Grants alternate A, B, A, B.
  - a_ready_o/b_ready_o each high only in their grant cycles.
- Same address, same edge: A->7=0xAAAA and B->7=0xBBBB accepted together.
  - Commits B (0xBBBB), then A (0xAAAA).
  - busy for 7 stays 1 until the second commit.
- Zero register: A->0 data 0xFFFF.
  - we3_o stays 0; a_ready_o returns to 1; busy1_o=0 for ra1_i=0.
- Reset mid-flight: B->9 accepted, reset_n pulsed low before commit.
  - we3_o never pulses; busy for 9 = 0; idle_o=1 immediately on reset assertion.
- Bypass (with RF_WB_BYPASS_EN): A->12=0x55 pending, ra2_i=12.
  - fwd2_hit_o=1, fwd2_o=0x55, busy2_o=0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter with a pending-write scoreboard.
// Optional operand forwarding when RF_WB_BYPASS_EN is defined.
module rf_wb_arbiter #(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          a_valid_i,
  output logic          a_ready_o,
  input  logic [4:0]    a_addr_i,
  input  logic [DW-1:0] a_data_i,
  input  logic          b_valid_i,
  output logic          b_ready_o,
  input  logic [4:0]    b_addr_i,
  input  logic [DW-1:0] b_data_i,
  output logic          we3_o,
  output logic [4:0]    a3_o,
  output logic [DW-1:0] wd3_o,
  input  logic [4:0]    ra1_i,
  input  logic [4:0]    ra2_i,
  output logic          busy1_o,
  output logic          busy2_o,
  output logic          idle_o
`ifdef RF_WB_BYPASS_EN
  ,
  output logic [DW-1:0] fwd1_o,
  output logic [DW-1:0] fwd2_o,
  output logic          fwd1_hit_o,
  output logic          fwd2_hit_o
`endif
);

  logic          a_full, b_full;
  logic [4:0]    a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic          b_older, rr_b;
  logic          both, same;
  logic          grant_a, grant_b, grant;
  logic          a_acc, b_acc;
  logic [4:0]    g_addr;
  logic [DW-1:0] g_data;
  logic [NREG-1:0] pending, pending_nxt;

  assign both = a_full && b_full;
  assign same = a_addr == b_addr;

  // Same destination must commit in fill order.
  always_comb begin
    grant_a = 1'b0;
    if (both && same)
      grant_a = !b_older;
    else if (both)
      grant_a = !rr_b;
    else
      grant_a = a_full;
  end

  assign grant_b = b_full && !grant_a;
  assign grant   = grant_a || grant_b;
  assign g_addr  = grant_b ? b_addr : a_addr;
  assign g_data  = grant_b ? b_data : a_data;

  assign a_ready_o = !a_full || grant_a;
  assign b_ready_o = !b_full || grant_b;
  assign a_acc     = a_valid_i && a_ready_o;
  assign b_acc     = b_valid_i && b_ready_o;

  assign idle_o = !a_full && !b_full && !we3_o;

  always_comb begin
    pending_nxt = '0;
    for (int r = 1; r < NREG; r++) begin
      pending_nxt[r] =
        (a_acc && a_addr_i == 5'(r)) ||
        (b_acc && b_addr_i == 5'(r)) ||
        (a_full && a_addr == 5'(r)) ||
        (b_full && b_addr == 5'(r)) ||
        (pending[r] &&
         !(we3_o && a3_o == 5'(r)));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_full  <= 1'b0;
      b_full  <= 1'b0;
      a_addr  <= '0;
      b_addr  <= '0;
      a_data  <= '0;
      b_data  <= '0;
      b_older <= 1'b0;
      rr_b    <= 1'b0;
      we3_o   <= 1'b0;
      a3_o    <= '0;
      wd3_o   <= '0;
      pending <= '0;
    end else begin
      if (a_acc) begin
        a_full <= 1'b1;
        a_addr <= a_addr_i;
        a_data <= a_data_i;
      end else if (grant_a) begin
        a_full <= 1'b0;
      end
      if (b_acc) begin
        b_full <= 1'b1;
        b_addr <= b_addr_i;
        b_data <= b_data_i;
      end else if (grant_b) begin
        b_full <= 1'b0;
      end
      if (a_acc)
        b_older <= 1'b1;
      else if (b_acc)
        b_older <= 1'b0;
      if (both)
        rr_b <= grant_a;
      we3_o <= grant && (g_addr != 5'd0);
      if (grant) begin
        a3_o  <= g_addr;
        wd3_o <= g_data;
      end
      pending <= pending_nxt;
    end
  end

`ifdef RF_WB_BYPASS_EN
  // Scan oldest to youngest so the youngest match wins.
  function automatic logic [DW:0] lookup(
    input logic [4:0] ra
  );
    logic [DW:0] res;
    res = '0;
    if (ra != 5'd0) begin
      if (we3_o && a3_o == ra)
        res = {1'b1, wd3_o};
      if (b_older) begin
        if (b_full && b_addr == ra)
          res = {1'b1, b_data};
        if (a_full && a_addr == ra)
          res = {1'b1, a_data};
      end else begin
        if (a_full && a_addr == ra)
          res = {1'b1, a_data};
        if (b_full && b_addr == ra)
          res = {1'b1, b_data};
      end
    end
    return res;
  endfunction

  assign {fwd1_hit_o, fwd1_o} = lookup(ra1_i);
  assign {fwd2_hit_o, fwd2_o} = lookup(ra2_i);
  assign busy1_o = pending[ra1_i] && !fwd1_hit_o;
  assign busy2_o = pending[ra2_i] && !fwd2_hit_o;
`else
  assign busy1_o = pending[ra1_i];
  assign busy2_o = pending[ra2_i];
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: expected commits are queued
// when stimulus is driven and popped at each commit.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [4:0]  ra1, ra2;
  logic        busy1, busy2, idle;
`ifdef RF_WB_BYPASS_EN
  logic [31:0] fwd1, fwd2;
  logic        fwd1_hit, fwd2_hit;
`endif

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t q[$];
  int  vec = 0;
  int  err = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .a_valid_i (a_valid),
    .a_ready_o (a_ready),
    .a_addr_i  (a_addr),
    .a_data_i  (a_data),
    .b_valid_i (b_valid),
    .b_ready_o (b_ready),
    .b_addr_i  (b_addr),
    .b_data_i  (b_data),
    .we3_o     (we3),
    .a3_o      (a3),
    .wd3_o     (wd3),
    .ra1_i     (ra1),
    .ra2_i     (ra2),
    .busy1_o   (busy1),
    .busy2_o   (busy2),
    .idle_o    (idle)
`ifdef RF_WB_BYPASS_EN
    ,
    .fwd1_o     (fwd1),
    .fwd2_o     (fwd2),
    .fwd1_hit_o (fwd1_hit),
    .fwd2_hit_o (fwd2_hit)
`endif
  );

  task automatic test_reset();
    reset_n = 1'b0;
    a_valid = 0; b_valid = 0;
    a_addr = 0; b_addr = 0;
    a_data = 0; b_data = 0;
    ra1 = 0; ra2 = 0;
    @(negedge clk);
    vec++;
    if (we3 !== 1'b0 || a3 !== 5'd0 ||
        wd3 !== 32'd0) begin
      err++;
      $display("FAIL reset_wport: we=%b a=%0d d=%h want 0",
               we3, a3, wd3);
    end
    vec++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1 ||
        idle !== 1'b1) begin
      err++;
      $display("FAIL reset_rdy: ar=%b br=%b idle=%b want 1",
               a_ready, b_ready, idle);
    end
    reset_n = 1'b1;
    @(negedge clk);
    vec++;
    if (idle !== 1'b1 || busy1 !== 1'b0) begin
      err++;
      $display("FAIL reset_rel: idle=%b busy1=%b want 1/0",
               idle, busy1);
    end
  endtask

  task automatic test_single();
    wr_t e;
    a_valid = 1; a_addr = 5; a_data = 32'h1234;
    ra1 = 5;
    q.push_back('{5'd5, 32'h1234});
    @(negedge clk);
    a_valid = 0;
    vec++;
    if (we3 !== 1'b0 || busy1 !== 1'b1) begin
      err++;
      $display("FAIL single_c1: we=%b busy1=%b want 0/1",
               we3, busy1);
    end
    @(negedge clk);
    e = q.pop_front();
    vec++;
    if (we3 !== 1'b1 || a3 !== e.addr ||
        wd3 !== e.data) begin
      err++;
      $display("FAIL single_commit: we=%b a=%0d d=%h want 1/%0d/%h",
               we3, a3, wd3, e.addr, e.data);
    end
    vec++;
    if (busy1 !== 1'b1) begin
      err++;
      $display("FAIL single_busy_c2: got %b want 1", busy1);
    end
    @(negedge clk);
    vec++;
    if (we3 !== 1'b0 || busy1 !== 1'b0 ||
        idle !== 1'b1) begin
      err++;
      $display("FAIL single_done: we=%b busy1=%b idle=%b want 0/0/1",
               we3, busy1, idle);
    end
  endtask

  task automatic test_contention();
    wr_t acur, bcur, e;
    int  ai, bi;
    bit  pend, ga;
    int  n;
    n = 8; ai = 1; bi = 1; pend = 0;
    acur = '{5'd3, 32'hA00};
    bcur = '{5'd4, 32'hB00};
    a_valid = 1; a_addr = acur.addr; a_data = acur.data;
    b_valid = 1; b_addr = bcur.addr; b_data = bcur.data;
    for (int k = 1; k <= n + 2; k++) begin
      @(negedge clk);
      vec++;
      if (pend) begin
        e = q.pop_front();
        if (we3 !== 1'b1 || a3 !== e.addr ||
            wd3 !== e.data) begin
          err++;
          $display("FAIL cont_commit k=%0d: we=%b a=%0d d=%h want 1/%0d/%h",
                   k, we3, a3, wd3, e.addr, e.data);
        end
      end else if (we3 !== 1'b0) begin
        err++;
        $display("FAIL cont_we k=%0d: got %b want 0", k, we3);
      end
      pend = 0;
      if (k <= n) begin
        ga = (k % 2) == 1;
        vec++;
        if (a_ready !== ga || b_ready !== !ga) begin
          err++;
          $display("FAIL cont_rdy k=%0d: ar=%b br=%b want %b/%b",
                   k, a_ready, b_ready, ga, !ga);
        end
        pend = 1;
        if (ga) begin
          q.push_back(acur);
          acur = '{5'(3 + 2 * ai), 32'hA00 + 32'(ai)};
          ai++;
          a_addr = acur.addr; a_data = acur.data;
        end else begin
          q.push_back(bcur);
          bcur = '{5'(4 + 2 * bi), 32'hB00 + 32'(bi)};
          bi++;
          b_addr = bcur.addr; b_data = bcur.data;
        end
        if (k == n) begin
          a_valid = 0; b_valid = 0;
        end
      end else if (k == n + 1) begin
        q.push_back(acur);
        pend = 1;
      end
    end
    @(negedge clk);
    vec++;
    if (we3 !== 1'b0 || idle !== 1'b1) begin
      err++;
      $display("FAIL cont_end: we=%b idle=%b want 0/1",
               we3, idle);
    end
  endtask

  task automatic test_same_addr();
    wr_t e;
    a_valid = 1; a_addr = 7; a_data = 32'hAAAA;
    b_valid = 1; b_addr = 7; b_data = 32'hBBBB;
    ra1 = 7;
    q.push_back('{5'd7, 32'hBBBB});
    q.push_back('{5'd7, 32'hAAAA});
    @(negedge clk);
    a_valid = 0; b_valid = 0;
    vec++;
    if (busy1 !== 1'b1 || we3 !== 1'b0) begin
      err++;
      $display("FAIL same_c1: busy1=%b we=%b want 1/0",
               busy1, we3);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      e = q.pop_front();
      vec++;
      if (we3 !== 1'b1 || a3 !== e.addr ||
          wd3 !== e.data || busy1 !== 1'b1) begin
        err++;
        $display("FAIL same_commit%0d: we=%b a=%0d d=%h busy=%b want 1/%0d/%h/1",
                 k, we3, a3, wd3, busy1, e.addr, e.data);
      end
    end
    @(negedge clk);
    vec++;
    if (busy1 !== 1'b0 || we3 !== 1'b0) begin
      err++;
      $display("FAIL same_done: busy1=%b we=%b want 0/0",
               busy1, we3);
    end
  endtask

  task automatic test_zero();
    a_valid = 1; a_addr = 0; a_data = 32'hFFFF;
    ra1 = 0;
    @(negedge clk);
    a_valid = 0;
    vec++;
    if (busy1 !== 1'b0 || a_ready !== 1'b1) begin
      err++;
      $display("FAIL zero_c1: busy1=%b ar=%b want 0/1",
               busy1, a_ready);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vec++;
      if (we3 !== 1'b0 || a_ready !== 1'b1 ||
          busy1 !== 1'b0) begin
        err++;
        $display("FAIL zero_c%0d: we=%b ar=%b busy1=%b want 0/1/0",
                 k + 2, we3, a_ready, busy1);
      end
    end
    vec++;
    if (idle !== 1'b1) begin
      err++;
      $display("FAIL zero_idle: got %b want 1", idle);
    end
  endtask

  task automatic test_reset_mid();
    b_valid = 1; b_addr = 9; b_data = 32'h9999;
    ra2 = 9;
    @(negedge clk);
    b_valid = 0;
    vec++;
    if (busy2 !== 1'b1) begin
      err++;
      $display("FAIL rmid_busy: got %b want 1", busy2);
    end
    #1 reset_n = 1'b0;
    #1;
    vec++;
    if (idle !== 1'b1 || busy2 !== 1'b0) begin
      err++;
      $display("FAIL rmid_async: idle=%b busy2=%b want 1/0",
               idle, busy2);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vec++;
      if (we3 !== 1'b0 || busy2 !== 1'b0) begin
        err++;
        $display("FAIL rmid_after%0d: we=%b busy2=%b want 0/0",
                 k, we3, busy2);
      end
    end
  endtask

`ifdef RF_WB_BYPASS_EN
  task automatic test_bypass();
    a_valid = 1; a_addr = 12; a_data = 32'h55;
    ra2 = 12;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      a_valid = 0;
      vec++;
      if (fwd2_hit !== 1'b1 || fwd2 !== 32'h55 ||
          busy2 !== 1'b0) begin
        err++;
        $display("FAIL bypass%0d: hit=%b d=%h busy2=%b want 1/55/0",
                 k, fwd2_hit, fwd2, busy2);
      end
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_same_addr();
    test_zero();
    test_reset_mid();
`ifdef RF_WB_BYPASS_EN
    test_bypass();
`endif
    vec++;
    if (q.size() != 0) begin
      err++;
      $display("FAIL queue_left: got %0d want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, err);
    $finish;
  end

endmodule
